// File: rtl/mm_axi_pkg.sv
// Shared types for the mem-request <-> AXI4-Lite bridges: response codes,
// master FSM states and the latched request record.
package mm_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Request addresses are held zero-extended so one record fits any ADDR_WIDTH.
    localparam int MAX_ADDR_WIDTH = 64;
    localparam int REQ_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WR_ADDR_DATA = 3'd1,
        ST_WR_RESP      = 3'd2,
        ST_RD_ADDR      = 3'd3,
        ST_RD_DATA      = 3'd4
    } state_t;

    typedef struct packed {
        logic [MAX_ADDR_WIDTH-1:0]   addr;
        logic                        we;
        logic [REQ_DATA_WIDTH-1:0]   wdata;
        logic [REQ_DATA_WIDTH/8-1:0] strb;
    } mem_req_t;

endpackage

// File: rtl/mem_to_axi_lite_master_if.sv
// AXI4-Lite bus between the mem-request master bridge and an AXI slave.
interface mem_to_axi_lite_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/mem_to_axi_lite_master.sv
// Turns single-word mem requests into AXI4-Lite master transactions, one outstanding.
// Optional MEM2AXI_HIDE_STRB_EN: all-zero-strobe writes complete locally without AXI traffic.
module mem_to_axi_lite_master
    import mm_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mem_req_i,
    output logic                    mem_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
    input  logic                    mem_we_i,
    input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] mem_strb_i,
    output logic                    mem_rvalid_o,
    output logic [DATA_WIDTH-1:0]   mem_rdata_o,
    output logic                    mem_err_o,
    mem_to_axi_lite_master_if.master m
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("mem_to_axi_lite_master: DATA_WIDTH must be 32");
    end
    if (ADDR_WIDTH > MAX_ADDR_WIDTH) begin : g_bad_addr_width
        $error("mem_to_axi_lite_master: ADDR_WIDTH too large");
    end

    state_t   state;
    mem_req_t req_q;
    logic     aw_done, w_done;
    logic     aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic     local_done;
    logic [MAX_ADDR_WIDTH-1:0] addr_ext;
    logic     unused_bits;

    assign mem_gnt_o = rst_n && (state == ST_IDLE) && mem_req_i;
    assign addr_ext  = MAX_ADDR_WIDTH'(mem_addr_i);

`ifdef MEM2AXI_HIDE_STRB_EN
    assign local_done = mem_we_i && (mem_strb_i == '0);
`else
    assign local_done = 1'b0;
`endif

    assign m.awaddr  = req_q.addr[ADDR_WIDTH-1:0];
    assign m.awprot  = 3'b000;
    assign m.awvalid = (state == ST_WR_ADDR_DATA) && !aw_done;
    assign m.wdata   = req_q.wdata;
    assign m.wstrb   = req_q.strb[STRB_WIDTH-1:0];
    assign m.wvalid  = (state == ST_WR_ADDR_DATA) && !w_done;
    assign m.bready  = (state == ST_WR_RESP);
    assign m.araddr  = req_q.addr[ADDR_WIDTH-1:0];
    assign m.arprot  = 3'b000;
    assign m.arvalid = (state == ST_RD_ADDR);
    assign m.rready  = (state == ST_RD_DATA);

    assign aw_hs = m.awvalid && m.awready;
    assign w_hs  = m.wvalid  && m.wready;
    assign b_hs  = m.bvalid  && m.bready;
    assign ar_hs = m.arvalid && m.arready;
    assign r_hs  = m.rvalid  && m.rready;

    assign unused_bits = ^{m.bresp[0], m.rresp[0], req_q.we, req_q.addr};

    // Request FSM; AW and W retire independently, completion is a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            req_q        <= '0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            mem_rvalid_o <= 1'b0;
            mem_rdata_o  <= '0;
            mem_err_o    <= 1'b0;
        end else begin
            mem_rvalid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mem_gnt_o) begin
                        req_q <= '{addr: addr_ext, we: mem_we_i,
                                   wdata: mem_wdata_i, strb: mem_strb_i};
                        if (local_done) begin
                            mem_rvalid_o <= 1'b1;
                            mem_err_o    <= 1'b0;
                        end else if (mem_we_i) begin
                            state <= ST_WR_ADDR_DATA;
                        end else begin
                            state <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WR_ADDR_DATA: begin
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        state   <= ST_WR_RESP;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        aw_done <= aw_done || aw_hs;
                        w_done  <= w_done || w_hs;
                    end
                end
                ST_WR_RESP: begin
                    if (b_hs) begin
                        state        <= ST_IDLE;
                        mem_rvalid_o <= 1'b1;
                        mem_err_o    <= m.bresp[1];
                    end
                end
                ST_RD_ADDR: begin
                    if (ar_hs) state <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (r_hs) begin
                        state        <= ST_IDLE;
                        mem_rvalid_o <= 1'b1;
                        mem_rdata_o  <= m.rdata;
                        mem_err_o    <= m.rresp[1];
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A response outside its wait state means the slave broke the protocol.
    a_b_in_state: assert property (@(posedge clk) disable iff (!rst_n)
        m.bvalid |-> state == ST_WR_RESP);
    a_r_in_state: assert property (@(posedge clk) disable iff (!rst_n)
        m.rvalid |-> state == ST_RD_DATA);

endmodule

// File: tb/tb_mem_to_axi_lite_master.sv
// Bench for mem_to_axi_lite_master: behavioural AXI slave with programmable ready
// latencies, table vectors, hand sequences and a random run against a reference model.
module tb_mem_to_axi_lite_master;
    import mm_axi_pkg::*;

`ifdef MEM2AXI_HIDE_STRB_EN
    localparam bit HIDE_ZERO_STRB = 1'b1;
    localparam int ZERO_STRB_LAT  = 1;
`else
    localparam bit HIDE_ZERO_STRB = 1'b0;
    localparam int ZERO_STRB_LAT  = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req = 1'b0, mem_gnt, mem_we = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
    logic [3:0]  mem_strb = '0;
    logic        mem_rvalid, mem_err;

    always #5 clk = ~clk;

    mem_to_axi_lite_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    mem_to_axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req_i(mem_req), .mem_gnt_o(mem_gnt), .mem_addr_i(mem_addr),
        .mem_we_i(mem_we), .mem_wdata_i(mem_wdata), .mem_strb_i(mem_strb),
        .mem_rvalid_o(mem_rvalid), .mem_rdata_o(mem_rdata), .mem_err_o(mem_err),
        .m(axi)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural AXI4-Lite slave: ready after N stalled cycles, B/R one cycle later.
    int unsigned aw_lat = 0, w_lat = 0, ar_lat = 0;
    bit          b_stall = 1'b0;
    logic [1:0]  resp_cfg = RESP_OKAY;
    logic [31:0] slave_mem [logic [29:0]];
    int          aw_cnt, w_cnt, ar_cnt, aw_hs_count;
    logic        aw_got, w_got, b_pend, r_pend, aw_now, w_now;
    logic [31:0] aw_addr_q, w_data_q, a_t, d_t, word_t, rdata_q;
    logic [3:0]  w_strb_q, s_t;
    logic [1:0]  bresp_q, rresp_q;

    assign axi.awready = axi.awvalid && (aw_cnt >= int'(aw_lat));
    assign axi.wready  = axi.wvalid  && (w_cnt  >= int'(w_lat));
    assign axi.arready = axi.arvalid && (ar_cnt >= int'(ar_lat));
    assign axi.bvalid  = b_pend && !b_stall;
    assign axi.bresp   = bresp_q;
    assign axi.rvalid  = r_pend;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            aw_addr_q <= '0; w_data_q <= '0; w_strb_q <= '0;
            bresp_q <= '0; rresp_q <= '0; rdata_q <= '0;
        end else begin
            aw_now = aw_got; a_t = aw_addr_q;
            w_now = w_got; d_t = w_data_q; s_t = w_strb_q;
            if (axi.awvalid && !axi.awready) aw_cnt <= aw_cnt + 1;
            if (axi.wvalid && !axi.wready) w_cnt <= w_cnt + 1;
            if (axi.arvalid && !axi.arready) ar_cnt <= ar_cnt + 1;
            if (axi.awvalid && axi.awready) begin
                aw_cnt <= 0; aw_now = 1'b1; a_t = axi.awaddr;
                aw_hs_count <= aw_hs_count + 1;
            end
            if (axi.wvalid && axi.wready) begin
                w_cnt <= 0; w_now = 1'b1; d_t = axi.wdata; s_t = axi.wstrb;
            end
            if (aw_now && w_now) begin
                word_t = slave_mem.exists(a_t[31:2]) ? slave_mem[a_t[31:2]] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (s_t[b]) word_t[8*b +: 8] = d_t[8*b +: 8];
                slave_mem[a_t[31:2]] = word_t;
                b_pend <= 1'b1; bresp_q <= resp_cfg;
                aw_now = 1'b0; w_now = 1'b0;
            end
            aw_got <= aw_now; aw_addr_q <= a_t;
            w_got <= w_now; w_data_q <= d_t; w_strb_q <= s_t;
            if (axi.bvalid && axi.bready) b_pend <= 1'b0;
            if (axi.arvalid && axi.arready) begin
                ar_cnt <= 0; r_pend <= 1'b1; rresp_q <= resp_cfg;
                rdata_q <= slave_mem.exists(axi.araddr[31:2]) ? slave_mem[axi.araddr[31:2]] : 32'h0;
            end
            if (axi.rvalid && axi.rready) r_pend <= 1'b0;
        end
    end

    // Monitor, sampled on the falling edge.
    typedef struct { logic [31:0] rdata; logic err; int cyc; } comp_t;
    comp_t       comp_q[$];
    int          last_ar_cyc = -1, last_aw_cyc = -1;
    logic [31:0] last_ar_addr = '0;
    logic [3:0]  last_wstrb = 4'hF;

    always @(negedge clk) begin
        if (mem_rvalid) comp_q.push_back('{mem_rdata, mem_err, cyc});
        if (axi.arvalid && axi.arready) begin last_ar_cyc = cyc; last_ar_addr = axi.araddr; end
        if (axi.awvalid && axi.awready) last_aw_cyc = cyc;
        if (axi.wvalid && axi.wready) last_wstrb = axi.wstrb;
    end

    // Reference model: flat word memory, reads return it, writes merge by strobe.
    typedef struct { logic [31:0] rdata; logic err; } exp_t;
    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] ref_last_rdata = '0;

    function automatic exp_t model_apply(logic we, logic [31:0] addr, logic [31:0] wdata,
                                         logic [3:0] strb, logic [1:0] resp);
        exp_t e;
        logic [31:0] word, mask;
        word = ref_mem.exists(addr[31:2]) ? ref_mem[addr[31:2]] : 32'h0;
        if (we) begin
            for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{strb[b]}};
            ref_mem[addr[31:2]] = (word & ~mask) | (wdata & mask);
            e.rdata = ref_last_rdata;
            e.err   = (HIDE_ZERO_STRB && strb == 4'h0) ? 1'b0 : resp[1];
        end else begin
            e.rdata = word;
            e.err   = resp[1];
            ref_last_rdata = word;
        end
        return e;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output int gcyc, output bit ok);
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata; mem_strb = strb;
        ok = 1'b0; gcyc = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (mem_gnt) begin ok = 1'b1; gcyc = cyc; end
        end
        @(posedge clk); #1;
        mem_req = 1'b0;
        if (!ok) check_output("gnt_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_comp(output comp_t c, output bit ok);
        ok = 1'b0; c = '{32'h0, 1'b0, 0};
        for (int i = 0; i < 40 && comp_q.size() == 0; i++) @(posedge clk);
        if (comp_q.size() > 0) begin c = comp_q.pop_front(); ok = 1'b1; end
        else check_output("completion_timeout", 32'(ok), 32'd1);
    endtask

    typedef struct {
        logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; logic [1:0] resp;
        logic [31:0] exp_rdata; logic exp_err; int exp_lat;
    } vec_t;

    task automatic apply_stimulus(input int idx, input vec_t v);
        int gcyc, aw_before;
        bit ok;
        comp_t c;
        resp_cfg = v.resp;
        aw_before = aw_hs_count;
        send(v.we, v.addr, v.wdata, v.strb, gcyc, ok);
        if (!ok) return;
        wait_comp(c, ok);
        if (!ok) return;
        check_output($sformatf("v%0d_rdata", idx), c.rdata, v.exp_rdata);
        check_output($sformatf("v%0d_err", idx), 32'(c.err), 32'(v.exp_err));
        check_output($sformatf("v%0d_latency", idx), 32'(c.cyc - gcyc), 32'(v.exp_lat));
        if (v.we && v.strb == 4'h0) begin
            if (HIDE_ZERO_STRB) check_output($sformatf("v%0d_aw_count", idx), 32'(aw_hs_count - aw_before), 32'd0);
            else check_output($sformatf("v%0d_wstrb", idx), 32'(last_wstrb), 32'd0);
        end else if (v.we) begin
            check_output($sformatf("v%0d_aw_cycle", idx), 32'(last_aw_cyc), 32'(gcyc + 1));
        end else begin
            check_output($sformatf("v%0d_ar_cycle", idx), 32'(last_ar_cyc), 32'(gcyc + 1));
            check_output($sformatf("v%0d_araddr", idx), last_ar_addr, v.addr);
        end
        repeat (2) @(posedge clk);
        check_output($sformatf("v%0d_single_pulse", idx), 32'(comp_q.size()), 32'd0);
    endtask

    vec_t vecs[9];

    initial begin
        int gcyc, aw_cycles, w_cycles, unstable;
        int gc[8];
        bit ok;
        comp_t c;
        exp_t e;
        exp_t exp_q[$];
        logic [31:0] idle_bits;

        // Reset: every output low, grant suppressed even with a request pending.
        mem_req = 1'b1;
        repeat (2) @(negedge clk);
        idle_bits = {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready,
                     mem_gnt, mem_rvalid, mem_err, |mem_rdata, |axi.awaddr};
        check_output("reset_outputs", idle_bits, 32'h0);
        @(posedge clk); #1;
        mem_req = 1'b0; rst_n = 1'b1;

        slave_mem[30'h4] = 32'hDEADBEEF;
        vecs[0] = '{1'b0, 32'h10, 32'h0,        4'h0, RESP_OKAY,   32'hDEADBEEF, 1'b0, 3};
        vecs[1] = '{1'b1, 32'h10, 32'hA5A50001, 4'h3, RESP_OKAY,   32'hDEADBEEF, 1'b0, 3};
        vecs[2] = '{1'b0, 32'h10, 32'h0,        4'h0, RESP_SLVERR, 32'hDEAD0001, 1'b1, 3};
        vecs[3] = '{1'b1, 32'h14, 32'h11223344, 4'hF, RESP_OKAY,   32'hDEAD0001, 1'b0, 3};
        vecs[4] = '{1'b0, 32'h14, 32'h0,        4'h0, RESP_OKAY,   32'h11223344, 1'b0, 3};
        vecs[5] = '{1'b1, 32'h20, 32'hFFFFFFFF, 4'h8, RESP_DECERR, 32'h11223344, 1'b1, 3};
        vecs[6] = '{1'b0, 32'h20, 32'h0,        4'h0, RESP_OKAY,   32'hFF000000, 1'b0, 3};
        vecs[7] = '{1'b1, 32'h24, 32'hCAFEF00D, 4'h0, RESP_OKAY,   32'hFF000000, 1'b0, ZERO_STRB_LAT};
        vecs[8] = '{1'b0, 32'h24, 32'h0,        4'h0, RESP_EXOKAY, 32'h00000000, 1'b0, 3};
        for (int i = 0; i < 9; i++) apply_stimulus(i, vecs[i]);

        // Slow AW: W retires alone, AW holds its payload until accepted.
        resp_cfg = RESP_OKAY; aw_lat = 2; w_lat = 0;
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h200; mem_wdata = 32'hA5A50001; mem_strb = 4'h3;
        ok = 1'b0; gcyc = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (mem_gnt) begin ok = 1'b1; gcyc = cyc; end
        end
        check_output("slow_aw_gnt", 32'(ok), 32'd1);
        @(posedge clk); #1;
        mem_req = 1'b0;
        aw_cycles = 0; w_cycles = 0; unstable = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (axi.awvalid) begin
                aw_cycles++;
                if (axi.awaddr !== 32'h200) unstable++;
            end
            if (axi.wvalid) begin
                w_cycles++;
                if (axi.wdata !== 32'hA5A50001 || axi.wstrb !== 4'h3) unstable++;
            end
        end
        check_output("slow_aw_awvalid_cycles", 32'(aw_cycles), 32'd3);
        check_output("slow_aw_wvalid_cycles", 32'(w_cycles), 32'd1);
        check_output("slow_aw_payload_stable", 32'(unstable), 32'd0);
        wait_comp(c, ok);
        check_output("slow_aw_latency", 32'(c.cyc - gcyc), 32'd5);
        check_output("slow_aw_err", 32'(c.err), 32'd0);
        aw_lat = 0;

        // Reset while waiting for B: everything drops at once, nothing completes.
        b_stall = 1'b1;
        send(1'b1, 32'h300, 32'h55AA55AA, 4'hF, gcyc, ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (axi.bready) ok = 1'b1;
        end
        check_output("reach_wr_resp", 32'(ok), 32'd1);
        #2;
        rst_n = 1'b0; mem_req = 1'b1; mem_we = 1'b0;
        #1;
        idle_bits = {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready,
                     mem_gnt, mem_rvalid, mem_err, |mem_rdata};
        check_output("midreset_outputs", idle_bits, 32'h0);
        b_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mem_req = 1'b0; rst_n = 1'b1;
        repeat (4) @(negedge clk);
        idle_bits = {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready};
        check_output("postreset_idle", idle_bits, 32'h0);
        check_output("postreset_no_completion", 32'(comp_q.size()), 32'd0);
        apply_stimulus(9, '{1'b0, 32'h10, 32'h0, 4'h0, RESP_OKAY, 32'hDEAD0001, 1'b0, 3});

        // Back-to-back alternating write/read with req held high, ready slave.
        ref_last_rdata = 32'hDEAD0001;
        resp_cfg = RESP_OKAY;
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = 1'b1;
        mem_addr = 32'h100 + 32'(4 * $urandom_range(0, 7));
        mem_wdata = $urandom; mem_strb = 4'($urandom_range(1, 15));
        for (int k = 0; k < 8; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 20 && !ok; i++) begin
                @(negedge clk);
                if (mem_gnt) ok = 1'b1;
            end
            if (!ok) begin
                check_output("b2b_gnt", 32'(ok), 32'd1);
                break;
            end
            gc[k] = cyc;
            exp_q.push_back(model_apply(mem_we, mem_addr, mem_wdata, mem_strb, resp_cfg));
            @(posedge clk); #1;
            if (k < 7) begin
                mem_we = ~mem_we;
                if (mem_we) mem_addr = 32'h100 + 32'(4 * $urandom_range(0, 7));
                mem_wdata = $urandom; mem_strb = 4'($urandom_range(1, 15));
            end else begin
                mem_req = 1'b0;
            end
        end
        mem_req = 1'b0;
        for (int i = 0; i < 60 && comp_q.size() < exp_q.size(); i++) @(posedge clk);
        check_output("b2b_count", 32'(comp_q.size()), 32'(exp_q.size()));
        for (int k = 1; k < exp_q.size(); k++)
            check_output($sformatf("b2b_gnt_spacing%0d", k), 32'(gc[k] - gc[k-1]), 32'd3);
        while (exp_q.size() > 0 && comp_q.size() > 0) begin
            e = exp_q.pop_front(); c = comp_q.pop_front();
            check_output("b2b_rdata", c.rdata, e.rdata);
            check_output("b2b_err", 32'(c.err), 32'(e.err));
        end
        exp_q.delete(); comp_q.delete();

        // Random traffic with random slave latencies and responses.
        for (int n = 0; n < 24; n++) begin
            logic        we;
            logic [31:0] addr, wdata;
            logic [3:0]  strb;
            aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3); ar_lat = $urandom_range(0, 3);
            resp_cfg = 2'($urandom_range(0, 3));
            we = 1'($urandom_range(0, 1));
            addr = 32'h100 + 32'(4 * $urandom_range(0, 7));
            wdata = $urandom; strb = 4'($urandom_range(0, 15));
            e = model_apply(we, addr, wdata, strb, resp_cfg);
            send(we, addr, wdata, strb, gcyc, ok);
            if (!ok) continue;
            wait_comp(c, ok);
            if (!ok) continue;
            check_output($sformatf("rnd%0d_rdata", n), c.rdata, e.rdata);
            check_output($sformatf("rnd%0d_err", n), 32'(c.err), 32'(e.err));
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] global timeout");
    end

endmodule
